// File: rtl/id_ex_ctrl_stage_if.sv
// Decode-to-execute control bundle: decoded lines in, registered lines out.
// The pipeline stage takes the slave side; the driver of decode takes master.
interface id_ex_ctrl_stage_if #(
    parameter int REG_SZ    = 5,
    parameter int ALU_OP_SZ = 3
);
    logic                 i_enable;
    logic                 i_flush_D;
    logic [ALU_OP_SZ-1:0] i_alu_op_MC;
    logic                 i_reg_dst_MC;
    logic                 i_jal_sel_MC;
    logic                 i_alu_src_MC;
    logic                 i_mem_read_MC;
    logic                 i_mem_write_MC;
    logic                 i_mem_to_reg_MC;
    logic                 i_reg_write_MC;
    logic                 i_halt_MC;
    logic [1:0]           i_bhw_MC;
    logic [REG_SZ-1:0]    i_rs_D;
    logic [REG_SZ-1:0]    i_rt_D;
    logic [REG_SZ-1:0]    i_rd_D;

    logic [ALU_OP_SZ-1:0] o_alu_op_E;
    logic                 o_reg_dst_E;
    logic                 o_jal_sel_E;
    logic                 o_alu_src_E;
    logic                 o_mem_read_E;
    logic                 o_mem_write_E;
    logic                 o_mem_to_reg_E;
    logic                 o_reg_write_E;
    logic                 o_halt_E;
    logic [1:0]           o_bhw_E;
    logic [REG_SZ-1:0]    o_rs_E;
    logic [REG_SZ-1:0]    o_rt_E;
    logic [REG_SZ-1:0]    o_rd_E;
    logic                 o_stall_D;
    logic                 o_halted;

    modport master (
        output i_enable, i_flush_D, i_alu_op_MC,
        output i_reg_dst_MC, i_jal_sel_MC, i_alu_src_MC,
        output i_mem_read_MC, i_mem_write_MC, i_mem_to_reg_MC,
        output i_reg_write_MC, i_halt_MC, i_bhw_MC,
        output i_rs_D, i_rt_D, i_rd_D,
        input  o_alu_op_E, o_reg_dst_E, o_jal_sel_E,
        input  o_alu_src_E, o_mem_read_E, o_mem_write_E,
        input  o_mem_to_reg_E, o_reg_write_E, o_halt_E,
        input  o_bhw_E, o_rs_E, o_rt_E, o_rd_E,
        input  o_stall_D, o_halted
    );

    modport slave (
        input  i_enable, i_flush_D, i_alu_op_MC,
        input  i_reg_dst_MC, i_jal_sel_MC, i_alu_src_MC,
        input  i_mem_read_MC, i_mem_write_MC, i_mem_to_reg_MC,
        input  i_reg_write_MC, i_halt_MC, i_bhw_MC,
        input  i_rs_D, i_rt_D, i_rd_D,
        output o_alu_op_E, o_reg_dst_E, o_jal_sel_E,
        output o_alu_src_E, o_mem_read_E, o_mem_write_E,
        output o_mem_to_reg_E, o_reg_write_E, o_halt_E,
        output o_bhw_E, o_rs_E, o_rt_E, o_rd_E,
        output o_stall_D, o_halted
    );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control register with load-use bubble insertion and HALT drain.
// Once a HALT is accepted the front end is frozen until reset.
module id_ex_ctrl_stage #(
    parameter int REG_SZ       = 5,
    parameter int ALU_OP_SZ    = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    id_ex_ctrl_stage_if.slave        bus
);

    typedef struct packed {
        logic [ALU_OP_SZ-1:0] alu_op;
        logic                 reg_dst;
        logic                 jal_sel;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic                 halt;
        logic [1:0]           bhw;
        logic [REG_SZ-1:0]    rs;
        logic [REG_SZ-1:0]    rt;
        logic [REG_SZ-1:0]    rd;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(DRAIN_CYCLES - 1);

    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  dec;
    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic   hz;

    // Gather the decoded instruction into one bundle.
    always_comb begin
        dec            = '0;
        dec.alu_op     = bus.i_alu_op_MC;
        dec.reg_dst    = bus.i_reg_dst_MC;
        dec.jal_sel    = bus.i_jal_sel_MC;
        dec.alu_src    = bus.i_alu_src_MC;
        dec.mem_read   = bus.i_mem_read_MC;
        dec.mem_write  = bus.i_mem_write_MC;
        dec.mem_to_reg = bus.i_mem_to_reg_MC;
        dec.reg_write  = bus.i_reg_write_MC;
        dec.halt       = bus.i_halt_MC;
        dec.bhw        = bus.i_bhw_MC;
        dec.rs         = bus.i_rs_D;
        dec.rt         = bus.i_rt_D;
        dec.rd         = bus.i_rd_D;
    end

    // Load in E whose destination feeds the instruction in D; $zero never counts.
    always_comb begin
        hz = ctrl_q.mem_read
           & (ctrl_q.rt != '0)
           & ((ctrl_q.rt == bus.i_rs_D) | (ctrl_q.rt == bus.i_rt_D));
    end

    // Next E contents and drain sequencing; disabled cycles hold everything.
    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.i_enable) begin
            unique case (state_q)
                RUN: begin
                    if (bus.i_flush_D || hz) begin
                        ctrl_d = '0;
                    end else begin
                        ctrl_d = dec;
                        if (dec.halt) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                DRAIN: begin
                    ctrl_d = '0;
                    if (cnt_q == 2'd0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                HALTED: begin
                    ctrl_d = '0;
                end
                default: begin
                    ctrl_d  = '0;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stage register, FSM state and drain counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ctrl_q  <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered execute-side outputs and front-end controls.
    always_comb begin
        bus.o_alu_op_E     = ctrl_q.alu_op;
        bus.o_reg_dst_E    = ctrl_q.reg_dst;
        bus.o_jal_sel_E    = ctrl_q.jal_sel;
        bus.o_alu_src_E    = ctrl_q.alu_src;
        bus.o_mem_read_E   = ctrl_q.mem_read;
        bus.o_mem_write_E  = ctrl_q.mem_write;
        bus.o_mem_to_reg_E = ctrl_q.mem_to_reg;
        bus.o_reg_write_E  = ctrl_q.reg_write;
        bus.o_halt_E       = ctrl_q.halt;
        bus.o_bhw_E        = ctrl_q.bhw;
        bus.o_rs_E         = ctrl_q.rs;
        bus.o_rt_E         = ctrl_q.rt;
        bus.o_rd_E         = ctrl_q.rd;
        bus.o_stall_D      = hz | (state_q != RUN);
        bus.o_halted       = (state_q == HALTED);
    end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Randomized and directed bench for id_ex_ctrl_stage against a
// cycle-level instruction model of the E slot and the HALT drain.
module tb_id_ex_ctrl_stage;

    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       jal_sel;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halt;
        logic [1:0] bhw;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    logic i_clk;
    logic i_reset;

    id_ex_ctrl_stage_if #(.REG_SZ(5), .ALU_OP_SZ(3)) bus ();

    id_ex_ctrl_stage #(
        .REG_SZ(5),
        .ALU_OP_SZ(3),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .bus(bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec;
    int n_err;

    // Model: what instruction sits in E, and how far the halt drain has gone.
    ins_t m_e;
    bit   m_halting;
    bit   m_halted;
    int   m_left;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic ins_t dut_e();
        ins_t e;
        e.alu_op     = bus.o_alu_op_E;
        e.reg_dst    = bus.o_reg_dst_E;
        e.jal_sel    = bus.o_jal_sel_E;
        e.alu_src    = bus.o_alu_src_E;
        e.mem_read   = bus.o_mem_read_E;
        e.mem_write  = bus.o_mem_write_E;
        e.mem_to_reg = bus.o_mem_to_reg_E;
        e.reg_write  = bus.o_reg_write_E;
        e.halt       = bus.o_halt_E;
        e.bhw        = bus.o_bhw_E;
        e.rs         = bus.o_rs_E;
        e.rt         = bus.o_rt_E;
        e.rd         = bus.o_rd_E;
        return e;
    endfunction

    function automatic ins_t addu(input int rs, input int rt, input int rd);
        ins_t x = '0;
        x.alu_op = 3'd2; x.reg_dst = 1; x.reg_write = 1; x.bhw = 2'd3;
        x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
        return x;
    endfunction

    function automatic ins_t addi(input int rs, input int rt);
        ins_t x = '0;
        x.alu_op = 3'd2; x.alu_src = 1; x.reg_write = 1; x.bhw = 2'd3;
        x.rs = 5'(rs); x.rt = 5'(rt);
        return x;
    endfunction

    function automatic ins_t lw(input int rs, input int rt);
        ins_t x = '0;
        x.alu_src = 1; x.mem_read = 1; x.mem_to_reg = 1; x.reg_write = 1;
        x.bhw = 2'd3; x.rs = 5'(rs); x.rt = 5'(rt);
        return x;
    endfunction

    function automatic ins_t sw(input int rs, input int rt);
        ins_t x = '0;
        x.alu_src = 1; x.mem_write = 1; x.bhw = 2'd3;
        x.rs = 5'(rs); x.rt = 5'(rt);
        return x;
    endfunction

    function automatic ins_t hlt();
        ins_t x = '0;
        x.halt = 1;
        return x;
    endfunction

    // A load in E stalls D only if D reads its nonzero destination.
    function automatic bit uses_load(input ins_t d);
        return m_e.mem_read && m_e.rt != 0 &&
               (m_e.rt == d.rs || m_e.rt == d.rt);
    endfunction

    task automatic step(input logic rst, input logic en, input logic fl,
                        input ins_t d);
        bit exp_stall;
        i_reset             = rst;
        bus.i_enable        = en;
        bus.i_flush_D       = fl;
        bus.i_alu_op_MC     = d.alu_op;
        bus.i_reg_dst_MC    = d.reg_dst;
        bus.i_jal_sel_MC    = d.jal_sel;
        bus.i_alu_src_MC    = d.alu_src;
        bus.i_mem_read_MC   = d.mem_read;
        bus.i_mem_write_MC  = d.mem_write;
        bus.i_mem_to_reg_MC = d.mem_to_reg;
        bus.i_reg_write_MC  = d.reg_write;
        bus.i_halt_MC       = d.halt;
        bus.i_bhw_MC        = d.bhw;
        bus.i_rs_D          = d.rs;
        bus.i_rt_D          = d.rt;
        bus.i_rd_D          = d.rd;
        #1;
        exp_stall = uses_load(d) || m_halting || m_halted;
        chk("stall_D", 32'(bus.o_stall_D), 32'(exp_stall));
        @(posedge i_clk);
        if (!rst) begin
            m_e = '0; m_halting = 0; m_halted = 0; m_left = 0;
        end else if (en) begin
            if (m_halting || m_halted) begin
                m_e = '0;
                if (m_halting) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_halting = 0;
                        m_halted  = 1;
                    end
                end
            end else if (fl || exp_stall) begin
                m_e = '0;
            end else begin
                m_e = d;
                if (d.halt) begin
                    m_halting = 1;
                    m_left    = DRAIN_CYCLES;
                end
            end
        end
        #1;
        chk("E_bundle", 32'(dut_e()), 32'(m_e));
        chk("halted", 32'(bus.o_halted), 32'(m_halted));
    endtask

    function automatic ins_t rnd_ins();
        ins_t x;
        x = ins_t'($urandom);
        x.halt = ($urandom_range(0, 14) == 0);
        x.rs = 5'($urandom_range(0, 3));
        x.rt = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom_range(0, 3));
        return x;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        m_e = '0; m_halting = 0; m_halted = 0; m_left = 0;
        i_reset = 0;
        bus.i_enable = 1;
        bus.i_flush_D = 0;
        bus.i_alu_op_MC = '0;
        bus.i_reg_dst_MC = 0;
        bus.i_jal_sel_MC = 0;
        bus.i_alu_src_MC = 0;
        bus.i_mem_read_MC = 0;
        bus.i_mem_write_MC = 0;
        bus.i_mem_to_reg_MC = 0;
        bus.i_reg_write_MC = 0;
        bus.i_halt_MC = 0;
        bus.i_bhw_MC = '0;
        bus.i_rs_D = '0;
        bus.i_rt_D = '0;
        bus.i_rd_D = '0;
        @(posedge i_clk);
        #1;

        // Reset held with ADDU decoding, then released.
        step(0, 1, 0, addu(1, 2, 3));
        step(0, 1, 0, addu(1, 2, 3));
        step(1, 1, 0, addu(1, 2, 3));

        // Load-use: one bubble, then the held ADDU loads.
        step(1, 1, 0, lw(5, 2));
        step(1, 1, 0, addu(1, 2, 3));
        step(1, 1, 0, addu(1, 2, 3));
        // Load into $zero never stalls.
        step(1, 1, 0, lw(5, 0));
        step(1, 1, 0, addu(0, 0, 3));

        // Independent instruction after a load, back-to-back loads.
        step(1, 1, 0, lw(5, 2));
        step(1, 1, 0, addu(3, 4, 1));
        step(1, 1, 0, lw(6, 7));
        step(1, 1, 0, lw(7, 1));

        // Flush beats hazard; next cycle E holds a bubble so no stall.
        step(1, 1, 0, lw(5, 2));
        step(1, 1, 1, sw(2, 2));
        step(1, 1, 0, sw(2, 2));

        // Stalled HALT retries, then drains and sticks.
        step(1, 1, 0, lw(5, 2));
        begin
            ins_t h = hlt();
            h.rs = 5'd2;
            step(1, 1, 0, h);
            step(1, 1, 0, h);
        end
        for (int i = 0; i < 6; i++) step(1, 1, 0, addu(1, 2, 3));

        // Reset out of HALTED, then ADDI loads normally.
        step(0, 1, 0, addi(1, 2));
        step(1, 1, 0, addi(1, 2));

        // Flushed HALT is not accepted.
        step(1, 1, 1, hlt());
        step(1, 1, 0, addu(1, 2, 3));

        // Enable gap mid-drain stretches it.
        step(1, 1, 0, hlt());
        step(1, 1, 0, addu(1, 2, 3));
        step(1, 0, 0, addu(1, 2, 3));
        step(1, 0, 0, addu(1, 2, 3));
        for (int i = 0; i < 4; i++) step(1, 1, 0, addu(1, 2, 3));

        // Reset mid-drain.
        step(0, 1, 0, addu(1, 2, 3));
        step(1, 1, 0, hlt());
        step(1, 1, 0, addu(1, 2, 3));
        step(0, 1, 0, addu(1, 2, 3));
        step(1, 1, 0, addu(1, 2, 3));

        // Random traffic with occasional flush, freeze and reset.
        for (int i = 0; i < 600; i++) begin
            logic r, e, f;
            r = ($urandom_range(0, 29) != 0);
            e = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 9) == 0);
            step(r, e, f, rnd_ins());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_stage.md
# id_ex_ctrl_stage

Registered decode-to-execute control stage of the 5-stage MIPS pipeline. It sits directly downstream of the main control unit and upstream of the execute stage. Each cycle it latches the decoded control lines and register specifiers, detects load-use hazards and inserts bubbles for them. It also runs the HALT drain sequence that freezes the front end and lets older instructions retire.

## Interface
Parameters:
- REG_SZ, 5, register specifier width
- ALU_OP_SZ, 3, alu_op width
- DRAIN_CYCLES, 3, cycles between HALT entering E and o_halted (E, M, WB retire)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_enable  in  1  debug-unit run/step enable; 0 freezes all state
- i_flush_D  in  1  squash the instruction currently in decode
- i_alu_op_MC  in  ALU_OP_SZ  decoded ALU op
- i_reg_dst_MC, i_jal_sel_MC, i_alu_src_MC, i_mem_read_MC, i_mem_write_MC, i_mem_to_reg_MC, i_reg_write_MC, i_halt_MC  in  1 each  decoded control lines
- i_bhw_MC  in  2  byte/half/word select
- i_rs_D, i_rt_D, i_rd_D  in  REG_SZ  decode-stage register specifiers
- o_alu_op_E  out  ALU_OP_SZ  registered alu_op
- o_reg_dst_E, o_jal_sel_E, o_alu_src_E, o_mem_read_E, o_mem_write_E, o_mem_to_reg_E, o_reg_write_E, o_halt_E  out  1 each  registered control lines
- o_bhw_E  out  2  registered bhw
- o_rs_E, o_rt_E, o_rd_E  out  REG_SZ  registered specifiers
- o_stall_D  out  1  hold PC and IF/ID register (combinational)
- o_halted  out  1  pipeline fully drained after HALT (registered)

## Operation
- Bubble = every _E control output 0; o_rs_E, o_rt_E and o_rd_E are also 0.
- Load-use hazard, combinational: hz = o_mem_read_E & (o_rt_E != 0) & (o_rt_E == i_rs_D | o_rt_E == i_rt_D).
- o_stall_D = hz | (state != RUN).
- FSM states: RUN, DRAIN, HALTED. A 2-bit down-counter cnt is used in DRAIN.
- RUN -> DRAIN when the instruction loaded into E has i_halt_MC=1 (accepted: enable=1, no flush, no hz). On that transition cnt is set to DRAIN_CYCLES-1.
- DRAIN: cnt decrements each enabled cycle. Go to HALTED when cnt==0 at the edge.
- HALTED is sticky and is left only by reset. o_halted=1 exactly in HALTED.
- Per enabled edge, in priority order:
  - reset: registers cleared
  - i_enable=0: hold everything
  - state != RUN: load a bubble
  - i_flush_D: load a bubble
  - hz: load a bubble (the D instruction is held upstream via o_stall_D)
  - otherwise: load the _MC and _D inputs
- A HALT that is flushed or stalled is not accepted. The FSM stays in RUN, and a stalled HALT retries on the next cycle.
- The zero register is never a hazard source. A rt==0 load produces no stall.

## Timing
- Latency is 1 cycle, from _MC/_D inputs to _E outputs.
- o_stall_D is combinational within the same cycle, from registered E state and current D inputs.
- A load-use hazard costs exactly 1 bubble. On the next cycle o_mem_read_E is 0, so hz=0 and the held instruction loads.
- Edge counting for HALT: the HALT is in E at edge 0. o_halted rises after DRAIN_CYCLES further enabled edges.
- o_halt_E is high for one cycle only; bubbles follow.
- Reset values:
  - all _E outputs 0
  - o_halted 0
  - state RUN, cnt 0
  - o_stall_D 0 (it follows reset state)
- Reset mid-DRAIN or in HALTED returns the block to RUN next cycle with outputs cleared.
- With i_enable=0 during DRAIN, cnt does not decrement.

## Test plan
- Reset: drive i_reset=0 with an ADDU decode for 2 cycles -> all outputs 0 and o_stall_D=0. Release reset -> ADDU controls (reg_dst=1, reg_write=1) appear on _E one edge later.
- Load-use: LW rt=2 enters E, and decode is ADDU rs=1 rt=2 -> o_stall_D=1 for 1 cycle and one bubble in E. ADDU appears in E the next cycle. Repeat with LW rt=0 -> no stall.
- Non-hazard load: LW rt=2 followed by ADDU rs=3 rt=4 -> no stall and back-to-back loads into E.
- Flush priority: i_flush_D=1 together with a hazard and a valid SW -> bubble loaded. Next cycle the stall clears if the hazard is gone.
- HALT drain: HALT accepted -> o_halt_E=1 for 1 cycle, o_stall_D=1 from the next cycle, o_halted=1 after 3 more edges and sticky. Pull i_enable=0 for 2 cycles mid-drain -> o_halted delayed by 2.
- Reset in HALTED: assert i_reset=0 -> state RUN, o_halted=0, o_stall_D=0. The next ADDI loads normally (alu_src=1, reg_write=1).
